// File: rtl/hazard_mdu_if.sv
// Hazard-controller bundle: pipeline hazard inputs from the datapath and stage controls back to it.
// MDU handshake: md_startE is held while the mult/div sits in E; md_done pulses for one cycle when its result is valid and it leaves E.
interface hazard_mdu_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 6
);
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
  logic [REG_AW-1:0] write_regE, write_regM, write_regW;
  logic              reg_writeE, reg_writeM, reg_writeW;
  logic              mem_to_regE, mem_to_regM;
  logic              branchD;
  logic              md_startE, md_is_divE;
  logic              dmem_stall, exceptionM;

  logic [1:0]        forward_AD, forward_BD, forward_AE, forward_BE;
  logic              stallF, stallD, stallE, stallM;
  logic              flushD, flushE, flushM, flushW;
  logic              md_busy, md_done;
  logic              md_state;
  logic [CNT_W-1:0]  md_cnt;

  modport master (
    output rsD, rtD, rsE, rtE, write_regE, write_regM, write_regW,
           reg_writeE, reg_writeM, reg_writeW, mem_to_regE, mem_to_regM,
           branchD, md_startE, md_is_divE, dmem_stall, exceptionM,
    input  forward_AD, forward_BD, forward_AE, forward_BE,
           stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
           md_busy, md_done, md_state, md_cnt
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, write_regE, write_regM, write_regW,
           reg_writeE, reg_writeM, reg_writeW, mem_to_regE, mem_to_regM,
           branchD, md_startE, md_is_divE, dmem_stall, exceptionM,
    output forward_AD, forward_BD, forward_AE, forward_BE,
           stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
           md_busy, md_done, md_state, md_cnt
  );
endinterface

// File: rtl/hazard_mdu.sv
// Hazard controller for the 5-stage core: forwarding, load-use/branch stalls,
// multi-cycle MDU stall engine, data-memory stall and precise exception flush.
module hazard_mdu #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input logic        clk,
  input logic        rst_n,
  hazard_mdu_if.slave hz
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lw_stall, br_stall, md_stall;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_m, flush_w;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] wr_m,
    input logic              we_m,
    input logic [REG_AW-1:0] wr_w,
    input logic              we_w
  );
    if (src != '0 && we_m && src == wr_m) return 2'b10;
    else if (src != '0 && we_w && src == wr_w) return 2'b01;
    else return 2'b00;
  endfunction

  assign hz.forward_AE = fwd_sel(hz.rsE, hz.write_regM, hz.reg_writeM, hz.write_regW, hz.reg_writeW);
  assign hz.forward_BE = fwd_sel(hz.rtE, hz.write_regM, hz.reg_writeM, hz.write_regW, hz.reg_writeW);
  assign hz.forward_AD = fwd_sel(hz.rsD, hz.write_regM, hz.reg_writeM, hz.write_regW, hz.reg_writeW);
  assign hz.forward_BD = fwd_sel(hz.rtD, hz.write_regM, hz.reg_writeM, hz.write_regW, hz.reg_writeW);

  assign lw_stall = hz.mem_to_regE && (hz.write_regE != '0) &&
                    (hz.write_regE == hz.rsD || hz.write_regE == hz.rtD);

  assign br_stall = hz.branchD &&
    ((hz.reg_writeE && hz.write_regE != '0 &&
      (hz.write_regE == hz.rsD || hz.write_regE == hz.rtD)) ||
     (hz.mem_to_regM && hz.write_regM != '0 &&
      (hz.write_regM == hz.rsD || hz.write_regM == hz.rtD)));

  // The cycle the op enters E already counts as its first stall cycle.
  assign md_stall   = (state == IDLE) ? hz.md_startE : (cnt != '0);
  assign hz.md_busy = (state == BUSY);
  assign hz.md_done = (state == BUSY) && (cnt == '0) && !hz.dmem_stall && !hz.exceptionM;
  assign hz.md_state = state;
  assign hz.md_cnt   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (hz.exceptionM) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!hz.dmem_stall) begin
      case (state)
        IDLE: if (hz.md_startE) begin
          state <= BUSY;
          cnt   <= hz.md_is_divE ? DIV_LOAD : MUL_LOAD;
        end
        BUSY: if (cnt == '0) state <= IDLE;
              else           cnt   <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_m = 1'b0; flush_w = 1'b0;
    if (hz.exceptionM) begin
      flush_d = 1'b1; flush_e = 1'b1; flush_m = 1'b1; flush_w = 1'b1;
    end else if (hz.dmem_stall) begin
      stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (md_stall) begin
      stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (lw_stall || br_stall) begin
      stall_f = 1'b1; stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.stallF = stall_f;
  assign hz.stallD = stall_d;
  assign hz.stallE = stall_e;
  assign hz.stallM = stall_m;
  assign hz.flushD = flush_d;
  assign hz.flushE = flush_e;
  assign hz.flushM = flush_m;
  assign hz.flushW = flush_w;
endmodule
